// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for mem_ctrl: FSM states, access lengths, owner codes.
// Optional build macro used by this slice: MEM_CTRL_FAIR_EN (round-robin arbitration).
package mem_ctrl_pkg;

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WORD_W = 32;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // mem_len_i codes (2'b11 is also a word)
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // Access owner
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    // Number of RAM byte cycles for a load/store length code
    function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return CNT_W'(1);
            LEN_HALF: return CNT_W'(2);
            default:  return CNT_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Grant logic between the MEM and IF requesters while the controller is idle.
// MEM_CTRL_FAIR_EN selects round-robin; otherwise MEM has fixed priority.
module mem_arbiter
    import mem_ctrl_pkg::*;
(
`ifdef MEM_CTRL_FAIR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic en,
    input  logic mem_req,
    input  logic if_req,
    output logic gnt_mem_c,
    output logic gnt_if_c
);

`ifdef MEM_CTRL_FAIR_EN
    logic last_grant;

    // Remember which port won the most recent grant
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_IF;
        end else if (gnt_mem_c) begin
            last_grant <= OWN_MEM;
        end else if (gnt_if_c) begin
            last_grant <= OWN_IF;
        end
    end

    // On contention the port not granted last wins
    always_comb begin
        gnt_mem_c = 1'b0;
        gnt_if_c  = 1'b0;
        if (en) begin
            if (mem_req && if_req) begin
                if (last_grant == OWN_MEM) begin
                    gnt_if_c = 1'b1;
                end else begin
                    gnt_mem_c = 1'b1;
                end
            end else begin
                gnt_mem_c = mem_req;
                gnt_if_c  = if_req;
            end
        end
    end
`else
    // MEM always wins on contention
    always_comb begin
        gnt_mem_c = en & mem_req;
        gnt_if_c  = en & if_req & ~mem_req;
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port owner: arbitrates IF fetches and MEM loads/stores,
// serialises each access into byte cycles and assembles little-endian words.
// Optional build macro: MEM_CTRL_FAIR_EN (round-robin arbitration in mem_arbiter).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_ready_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_ready_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_data_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_data_i
);

    generate
        if (RAM_RD_LAT != 1) begin : g_bad_lat
            $error("mem_ctrl: only RAM_RD_LAT == 1 is supported");
        end
    endgenerate

    logic [1:0]        state_q, state_n;
    logic              owner_q, owner_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [CNT_W-1:0]  n_q, n_n, k_q, k_n;
    logic [WORD_W-1:0] wdata_q, wdata_n, asm_q, asm_n;
    logic [WORD_W-1:0] if_data_n, mem_rdata_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [7:0]        ram_data_n;
    logic              ram_wr_n, if_rdy_q, if_rdy_n, mem_ready_n;
    logic              gnt_mem_c, gnt_if_c, flush_hit_c;

    mem_arbiter u_arb (
`ifdef MEM_CTRL_FAIR_EN
        .clk       (clk),
        .rst       (rst),
`endif
        .en        (state_q == ST_IDLE),
        .mem_req   (mem_req_i),
        .if_req    (if_req_i & ~if_flush_i),
        .gnt_mem_c (gnt_mem_c),
        .gnt_if_c  (gnt_if_c)
    );

    assign flush_hit_c = if_flush_i && (owner_q == OWN_IF) &&
                         ((state_q == ST_RD) || (state_q == ST_DONE));

    // A flush landing in DONE still withholds the fetch ready pulse
    assign if_ready_o = if_rdy_q & ~if_flush_i;

    // Next state, byte sequencing and registered-output values
    always_comb begin
        state_n     = state_q;
        owner_n     = owner_q;
        addr_n      = addr_q;
        n_n         = n_q;
        k_n         = k_q;
        wdata_n     = wdata_q;
        asm_n       = asm_q;
        if_data_n   = if_data_o;
        mem_rdata_n = mem_rdata_o;
        ram_addr_n  = '0;
        ram_data_n  = '0;
        ram_wr_n    = 1'b0;
        if_rdy_n    = 1'b0;
        mem_ready_n = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_mem_c || gnt_if_c) begin
                    owner_n = gnt_mem_c ? OWN_MEM : OWN_IF;
                    addr_n  = gnt_mem_c ? mem_addr_i : if_addr_i;
                    n_n     = gnt_mem_c ? len_bytes(mem_len_i) : CNT_W'(4);
                    wdata_n = mem_wdata_i;
                    k_n     = '0;
                    asm_n   = '0;
                    state_n = (gnt_mem_c && mem_we_i) ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                if (k_q != '0) begin
                    asm_n[{2'(k_q - CNT_W'(1)), 3'b000} +: 8] = ram_data_i;
                end
                if (flush_hit_c) begin
                    state_n = ST_IDLE;
                end else if (k_q == n_q) begin
                    state_n = ST_DONE;
                    if (owner_q == OWN_IF) begin
                        if_data_n = asm_n;
                    end else begin
                        mem_rdata_n = asm_n;
                    end
                end else begin
                    k_n = k_q + CNT_W'(1);
                end
            end
            ST_WR: begin
                if (k_q == n_q - CNT_W'(1)) begin
                    state_n = ST_DONE;
                end else begin
                    k_n = k_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (((state_n == ST_RD) && (k_n < n_n)) || (state_n == ST_WR)) begin
            ram_addr_n = addr_n + ADDR_W'(k_n);
        end
        if (state_n == ST_WR) begin
            ram_wr_n   = 1'b1;
            ram_data_n = wdata_n[{2'(k_n), 3'b000} +: 8];
        end
        if (state_n == ST_DONE) begin
            if_rdy_n    = (owner_n == OWN_IF);
            mem_ready_n = (owner_n == OWN_MEM);
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            n_q         <= '0;
            k_q         <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
            ram_addr_o  <= '0;
            ram_data_o  <= '0;
            ram_wr_o    <= 1'b0;
            if_rdy_q    <= 1'b0;
            mem_ready_o <= 1'b0;
        end else begin
            state_q     <= state_n;
            owner_q     <= owner_n;
            addr_q      <= addr_n;
            n_q         <= n_n;
            k_q         <= k_n;
            wdata_q     <= wdata_n;
            asm_q       <= asm_n;
            if_data_o   <= if_data_n;
            mem_rdata_o <= mem_rdata_n;
            ram_addr_o  <= ram_addr_n;
            ram_data_o  <= ram_data_n;
            ram_wr_o    <= ram_wr_n;
            if_rdy_q    <= if_rdy_n;
            mem_ready_o <= mem_ready_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected responses, RAM
// reads and RAM writes (with cycle stamps); a monitor pops and compares.
module tb_mem_ctrl;

    localparam int unsigned ADDR_W = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        chk_data;
        logic [31:0] cyc;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } ram_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i, if_flush_i, if_ready_o;
    logic [ADDR_W-1:0] if_addr_i;
    logic [31:0]       if_data_o;
    logic              mem_req_i, mem_we_i, mem_ready_o;
    logic [1:0]        mem_len_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i, mem_rdata_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [7:0]        ram_data_o, ram_data_i;
    logic              ram_wr_o;

    logic [7:0]  ram [0:4095];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    rsp_t        if_q[$], mem_q[$];
    ram_t        wr_q[$], rd_q[$];
    rsp_t        mon_r;
    ram_t        mon_w;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(ADDR_W), .RAM_RD_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_ready_o  (if_ready_o),
        .if_data_o   (if_data_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_len_i   (mem_len_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_wr_o    (ram_wr_o),
        .ram_data_i  (ram_data_i)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: one-cycle read latency; fixed contents preloaded during reset
    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_addr_o[11:0]] <= ram_data_o;
        ram_data_i <= ram[ram_addr_o[11:0]];
        if (rst) begin
            ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05;
            ram[12'h102] <= 8'h00; ram[12'h103] <= 8'h00;
            ram[12'hFFE] <= 8'h11; ram[12'hFFF] <= 8'h22;
            ram[12'h000] <= 8'h33; ram[12'h001] <= 8'h44;
            ram[12'h403] <= 8'h77;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare every presented response and RAM cycle to the queues
    always @(negedge clk) begin
        if (mon_en) begin
            if (if_ready_o) begin
                if (if_q.size() == 0) chk("if_ready_unexpected", 64'(if_ready_o), 64'd0);
                else begin
                    mon_r = if_q.pop_front();
                    chk("if_data", 64'(if_data_o), 64'(mon_r.data));
                    chk("if_ready_cycle", 64'(cyc), 64'(mon_r.cyc));
                end
            end
            if (mem_ready_o) begin
                if (mem_q.size() == 0) chk("mem_ready_unexpected", 64'(mem_ready_o), 64'd0);
                else begin
                    mon_r = mem_q.pop_front();
                    if (mon_r.chk_data) chk("mem_rdata", 64'(mem_rdata_o), 64'(mon_r.data));
                    chk("mem_ready_cycle", 64'(cyc), 64'(mon_r.cyc));
                end
            end
            if (ram_wr_o) begin
                if (wr_q.size() == 0) chk("ram_wr_unexpected", 64'(ram_wr_o), 64'd0);
                else begin
                    mon_w = wr_q.pop_front();
                    chk("ram_wr_addr", 64'(ram_addr_o), 64'(mon_w.addr));
                    chk("ram_wr_data", 64'(ram_data_o), 64'(mon_w.data));
                    chk("ram_wr_cycle", 64'(cyc), 64'(mon_w.cyc));
                end
            end
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
                mon_w = rd_q.pop_front();
                chk("ram_rd_addr", {31'd0, ram_wr_o, ram_addr_o}, {32'd0, mon_w.addr});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [31:0] a, input int unsigned c);
        ram_t e;
        e.addr = a; e.data = 8'h00; e.cyc = c;
        rd_q.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int unsigned c);
        ram_t e;
        e.addr = a; e.data = d; e.cyc = c;
        wr_q.push_back(e);
    endtask

    task automatic push_rsp(input bit is_if, input logic [31:0] d, input bit cd, input int unsigned c);
        rsp_t e;
        e.data = d; e.chk_data = cd; e.cyc = c;
        if (is_if) if_q.push_back(e);
        else mem_q.push_back(e);
    endtask

    // Wait (bounded) for a ready pulse, then return just after the edge ending DONE
    task automatic wait_ready(input bit is_if, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = is_if ? if_ready_o : mem_ready_o;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", name);
        end
        step();
    endtask

    task automatic do_if(input logic [31:0] a, input logic [31:0] exp);
        int unsigned c0 = cyc;
        for (int k = 0; k < 4; k++) push_rd(a + 32'(k), c0 + 1 + k);
        push_rsp(1'b1, exp, 1'b1, c0 + 6);
        if_addr_i = a;
        if_req_i  = 1'b1;
        wait_ready(1'b1, "if");
        if_req_i  = 1'b0;
    endtask

    task automatic do_mem(input bit we, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp);
        int unsigned c0 = cyc;
        int unsigned n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        logic [31:0] sh;
        for (int k = 0; k < int'(n); k++) begin
            sh = wd >> (8 * k);
            if (we) push_wr(a + 32'(k), sh[7:0], c0 + 1 + k);
            else    push_rd(a + 32'(k), c0 + 1 + k);
        end
        push_rsp(1'b0, exp, !we, we ? c0 + n + 1 : c0 + n + 2);
        mem_we_i = we; mem_len_i = len; mem_addr_i = a; mem_wdata_i = wd;
        mem_req_i = 1'b1;
        wait_ready(1'b0, "mem");
        mem_req_i = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ram_addr"},  64'(ram_addr_o),  64'd0);
        chk({tag, "_ram_data"},  64'(ram_data_o),  64'd0);
        chk({tag, "_ram_wr"},    64'(ram_wr_o),    64'd0);
        chk({tag, "_if_ready"},  64'(if_ready_o),  64'd0);
        chk({tag, "_if_data"},   64'(if_data_o),   64'd0);
        chk({tag, "_mem_ready"}, 64'(mem_ready_o), 64'd0);
        chk({tag, "_mem_rdata"}, 64'(mem_rdata_o), 64'd0);
    endtask

    initial begin
        int unsigned c0;
        rst = 1'b1;
        if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00;
        mem_addr_i = '0; mem_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("reset");
        mon_en = 1'b1;
        step();

        // Basic fetch, stores and loads of each length
        do_if(32'h100, 32'h0000_0513);
        do_mem(1'b1, 2'b10, 32'h200, 32'hDEAD_BEEF, 32'h0);
        do_mem(1'b0, 2'b00, 32'h202, 32'h0, 32'h0000_00AD);
        do_mem(1'b0, 2'b01, 32'h201, 32'h0, 32'h0000_ADBE);
        do_mem(1'b1, 2'b00, 32'h203, 32'hCAFE_BA55, 32'h0);
        do_mem(1'b0, 2'b11, 32'h200, 32'h0, 32'h55AD_BEEF);
        do_mem(1'b1, 2'b01, 32'h204, 32'hA5A5_1234, 32'h0);
        do_mem(1'b0, 2'b01, 32'h204, 32'h0, 32'h0000_1234);

        // Address wrap-around
        do_if(32'hFFFF_FFFE, 32'h4433_2211);

        // Simultaneous requests: MEM first, IF right after
        c0 = cyc;
        push_rd(32'h200, c0 + 1);
        push_rsp(1'b0, 32'h0000_00EF, 1'b1, c0 + 3);
        for (int k = 0; k < 4; k++) push_rd(32'h100 + 32'(k), c0 + 5 + k);
        push_rsp(1'b1, 32'h0000_0513, 1'b1, c0 + 10);
        mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h200; mem_req_i = 1'b1;
        if_addr_i = 32'h100; if_req_i = 1'b1;
        wait_ready(1'b0, "both_mem");
        mem_req_i = 1'b0;
        wait_ready(1'b1, "both_if");
        if_req_i = 1'b0;

        // Flush during a fetch, flush blocks a grant, then fetch at the target
        c0 = cyc;
        push_rd(32'h300, c0 + 1);
        push_rd(32'h301, c0 + 2);
        if_addr_i = 32'h300; if_req_i = 1'b1;
        step();
        step();
        if_flush_i = 1'b1; if_addr_i = 32'h100;
        step();
        step();
        if_flush_i = 1'b0;
        for (int k = 0; k < 4; k++) push_rd(32'h100 + 32'(k), c0 + 5 + k);
        push_rsp(1'b1, 32'h0000_0513, 1'b1, c0 + 10);
        wait_ready(1'b1, "flush_if");
        if_req_i = 1'b0;

        // Reset in the middle of a word store
        c0 = cyc;
        push_wr(32'h400, 8'h44, c0 + 1);
        push_wr(32'h401, 8'h33, c0 + 2);
        push_wr(32'h402, 8'h22, c0 + 3);
        mem_we_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = 32'h400;
        mem_wdata_i = 32'h1122_3344; mem_req_i = 1'b1;
        step();
        step();
        step();
        rst = 1'b1; mem_req_i = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midrst");
        step();
        do_mem(1'b0, 2'b10, 32'h400, 32'h0, 32'h7722_3344);

        repeat (3) step();
        chk("if_q_drained",  64'(if_q.size()),  64'd0);
        chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
        chk("wr_q_drained",  64'(wr_q.size()),  64'd0);
        chk("rd_q_drained",  64'(rd_q.size()),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
